// File: rtl/iq_modulate.sv
// iq_modulate: NCO carrier with AM/FM/PM modulation from a decimated
// sample stream, quarter-wave sine table and a fixed 4-stage output pipe.
module iq_modulate #(
  parameter int unsigned PHASE_WIDTH  = 32,
  parameter int unsigned INPUT_WIDTH  = 12,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned LUT_AW       = 10,
  parameter int unsigned DECIM        = 100,
  parameter int unsigned FM_SHIFT     = 8
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic [PHASE_WIDTH-1:0]  Fre_word,
  input  logic [1:0]              mode,
  input  logic [INPUT_WIDTH-1:0]  mod_in,
  input  logic                    mod_valid,
  output logic                    mod_ready,
  output logic [OUTPUT_WIDTH-1:0] wave_out,
  output logic                    out_valid,
  output logic                    underrun
);

  localparam int unsigned PW    = PHASE_WIDTH;
  localparam int unsigned IW    = INPUT_WIDTH;
  localparam int unsigned OW    = OUTPUT_WIDTH;
  localparam int unsigned PA    = LUT_AW + 2;
  localparam int unsigned PRW   = OW + IW + 1;
  localparam int unsigned CW    = (DECIM > 2) ? $clog2(DECIM) : 1;
  localparam int unsigned LUT_N = 1 << LUT_AW;
  localparam int unsigned AMP   = (1 << (OW - 1)) - 1;
  localparam real         PI    = 3.14159265358979323846;
  localparam logic [IW-1:0] ENV_BIAS = IW'(1) << (IW - 1);

  typedef enum logic [1:0] {
    MODE_AM      = 2'd0,
    MODE_FM      = 2'd1,
    MODE_PM      = 2'd2,
    MODE_CARRIER = 2'd3
  } mode_e;

  // First quadrant of the sine, rounded to the nearest integer magnitude
  logic [OW-2:0] lut_rom [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    assign lut_rom[gi] = (OW - 1)'($rtoi(real'(AMP) *
                         $sin(2.0 * PI * real'(gi) / real'(4 * LUT_N)) + 0.5));
  end

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mod_ready_q, mod_ready_d;
  logic [IW-1:0]     sample_q, sample_d;
  mode_e             mode_q, mode_d;
  logic              underrun_q, underrun_d;
  logic [PW-1:0]     phase_acc_q, phase_acc_d;
  logic [PA-1:0]     p1_q, p1_d;
  logic              am1_q, am1_d, am2_q, am2_d, am3_q, am3_d;
  logic [IW-1:0]     env1_q, env1_d, env2_q, env2_d, env3_q, env3_d;
  logic [OW-2:0]     lut2_q, lut2_d;
  logic [1:0]        quad2_q, quad2_d;
  logic              peak2_q, peak2_d;
  logic [OW-1:0]     s3_q, s3_d;
  logic [OW-1:0]     wave_q, wave_d;
  logic [3:0]        vld_q, vld_d;

  logic [PW-1:0]     inc_c;
  logic [PA-1:0]     pm_off_c;
  logic [1:0]        quad_c;
  logic [LUT_AW-1:0] idx_c, addr_c;
  logic [OW-1:0]     mag_c;

  // Next-state logic: sample handshake, accumulator and the four pipe stages
  always_comb begin
    cnt_d       = (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + CW'(1);
    mod_ready_d = (cnt_d == CW'(DECIM - 1));
    sample_d    = sample_q;
    mode_d      = mode_q;
    underrun_d  = underrun_q;
    if (mod_ready_q) begin
      if (mod_valid) begin
        sample_d = mod_in;
        mode_d   = mode_e'(mode);
      end else begin
        underrun_d = 1'b1;
      end
    end

    inc_c = Fre_word;
    if (mode_q == MODE_FM) begin
      inc_c = Fre_word + (PW'($signed(sample_q)) << FM_SHIFT);
    end
    phase_acc_d = phase_acc_q + inc_c;

    // Stage 1: PM offset only touches the top bits, so sum just the table index bits
    pm_off_c = '0;
    if (mode_q == MODE_PM) begin
      pm_off_c = PA'((PW'(sample_q) << (PW - IW)) >> (PW - PA));
    end
    p1_d   = phase_acc_q[PW-1 -: PA] + pm_off_c;
    am1_d  = (mode_q == MODE_AM);
    env1_d = sample_q ^ ENV_BIAS;

    // Stage 2: mirror the address in odd quadrants; index 0 there is the peak
    quad_c  = p1_q[PA-1 -: 2];
    idx_c   = p1_q[LUT_AW-1:0];
    addr_c  = quad_c[0] ? (LUT_AW'(0) - idx_c) : idx_c;
    lut2_d  = lut_rom[addr_c];
    quad2_d = quad_c;
    peak2_d = quad_c[0] && (idx_c == '0);
    am2_d   = am1_q;
    env2_d  = env1_q;

    // Stage 3: restore the full-scale peak and negate the lower half-cycle
    mag_c = peak2_q ? OW'(AMP) : {1'b0, lut2_q};
    s3_d  = quad2_q[1] ? (OW'(0) - mag_c) : mag_c;
    am3_d = am2_q;
    env3_d = env2_q;

    // Stage 4: AM scales by the unsigned envelope, other modes pass the carrier
    wave_d = s3_q;
    if (am3_q) begin
      wave_d = OW'((PRW'($signed(s3_q)) * PRW'($signed({1'b0, env3_q}))) >>> IW);
    end

    vld_d = {vld_q[2:0], 1'b1};
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (RST) begin
      cnt_q       <= '0;
      mod_ready_q <= 1'b0;
      sample_q    <= '0;
      mode_q      <= MODE_CARRIER;
      underrun_q  <= 1'b0;
      phase_acc_q <= '0;
      p1_q        <= '0;
      am1_q       <= 1'b0;
      env1_q      <= '0;
      lut2_q      <= '0;
      quad2_q     <= '0;
      peak2_q     <= 1'b0;
      am2_q       <= 1'b0;
      env2_q      <= '0;
      s3_q        <= '0;
      am3_q       <= 1'b0;
      env3_q      <= '0;
      wave_q      <= '0;
      vld_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mod_ready_q <= mod_ready_d;
      sample_q    <= sample_d;
      mode_q      <= mode_d;
      underrun_q  <= underrun_d;
      phase_acc_q <= phase_acc_d;
      p1_q        <= p1_d;
      am1_q       <= am1_d;
      env1_q      <= env1_d;
      lut2_q      <= lut2_d;
      quad2_q     <= quad2_d;
      peak2_q     <= peak2_d;
      am2_q       <= am2_d;
      env2_q      <= env2_d;
      s3_q        <= s3_d;
      am3_q       <= am3_d;
      env3_q      <= env3_d;
      wave_q      <= wave_d;
      vld_q       <= vld_d;
    end
  end

  assign mod_ready = mod_ready_q;
  assign wave_out  = wave_q;
  assign out_valid = vld_q[3];
  assign underrun  = underrun_q;

endmodule
